// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 frame scheduler slice.
//   state_t    : scheduler FSM encoding (S_IDLE, S_HOLD)
//   frame_w()  : frame width in bits for a cascade of SIZE 8x8 modules
//   cnt_width(): bits needed to hold values 0..n-1 (at least 1 bit)
package max7219_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    function automatic int frame_w(input int size);
        return 64 * size;
    endfunction

    // Counters only ever reach n-1, so clog2(n) bits suffice; a zero-width
    // vector is not legal, hence the 1-bit floor.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/max7219_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector, one bit per requester
//   last        : index of the previously granted requester
//   grant       : one-hot grant (all zero when no request)
//   grant_idx   : binary index of the granted requester (== last when none)
//   grant_valid : at least one request was present
// Search starts at last+1 and wraps, so the previous owner has lowest priority.
module rr_arbiter
    import max7219_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]            req,
    input  logic [cnt_width(NREQ)-1:0] last,
    output logic [NREQ-1:0]            grant,
    output logic [cnt_width(NREQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int IW = cnt_width(NREQ);

    int cand;

    always_comb begin
        grant       = '0;
        grant_idx   = last;
        grant_valid = 1'b0;
        cand        = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = int'(last) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_valid && req[cand[IW-1:0]]) begin
                grant_valid            = 1'b1;
                grant_idx              = cand[IW-1:0];
                grant[cand[IW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/max7219_frame_scheduler.sv
// Shares a cascaded MAX7219 matrix display between NREQ frame producers.
// A round-robin winner's frame is latched into the pixel register, then held
// for HOLD_CYCLES cycles before another grant is possible. With
// BLANK_CYCLES != 0 the display is cleared after that many request-free idle
// cycles.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   req      : req[k] = requester k presents a frame on frame_in slice k
//   frame_in : NREQ packed frames, slice k at [FW*(k+1)-1 -: FW]
//   ack      : one-cycle one-hot pulse, frame of requester k was latched
//   pixels   : registered frame to the display driver
//   owner    : index of the last granted requester
//   busy     : high while the current frame is being held
//   blanked  : high while pixels were cleared by the idle timeout
module max7219_frame_scheduler
    import max7219_pkg::*;
#(
    parameter int SIZE         = 2,
    parameter int NREQ         = 2,
    parameter int HOLD_CYCLES  = 25_000_000,
    parameter int BLANK_CYCLES = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*frame_w(SIZE)-1:0]   frame_in,
    output logic [NREQ-1:0]                 ack,
    output logic [frame_w(SIZE)-1:0]        pixels,
    output logic [cnt_width(NREQ)-1:0]      owner,
    output logic                            busy,
    output logic                            blanked
);

    localparam int FW = frame_w(SIZE);
    localparam int OW = cnt_width(NREQ);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int IW = cnt_width(BLANK_CYCLES);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    // Unpack the frame bus into one entry per requester.
    logic [FW-1:0] slice [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice[gi] = frame_in[FW*(gi+1)-1 -: FW];
        end
    endgenerate

    state_t          state_reg,    state_next;
    logic [FW-1:0]   pixels_reg,   pixels_next;
    logic [NREQ-1:0] ack_reg,      ack_next;
    logic [OW-1:0]   owner_reg,    owner_next;
    logic            busy_reg,     busy_next;
    logic            blanked_reg,  blanked_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [IW-1:0]   idle_cnt_reg, idle_cnt_next;

    logic [NREQ-1:0] grant;
    logic [OW-1:0]   grant_idx;
    logic            grant_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arbiter (
        .req         (req),
        .last        (owner_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            pixels_reg   <= '0;
            ack_reg      <= '0;
            owner_reg    <= OW'(NREQ - 1);
            busy_reg     <= 1'b0;
            blanked_reg  <= 1'b1;
            hold_cnt_reg <= '0;
            idle_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pixels_reg   <= pixels_next;
            ack_reg      <= ack_next;
            owner_reg    <= owner_next;
            busy_reg     <= busy_next;
            blanked_reg  <= blanked_next;
            hold_cnt_reg <= hold_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pixels_next   = pixels_reg;
        ack_next      = '0;
        owner_next    = owner_reg;
        busy_next     = busy_reg;
        blanked_next  = blanked_reg;
        hold_cnt_next = hold_cnt_reg;
        idle_cnt_next = idle_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (grant_valid) begin
                    pixels_next   = slice[grant_idx];
                    ack_next      = grant;
                    owner_next    = grant_idx;
                    blanked_next  = 1'b0;
                    busy_next     = 1'b1;
                    hold_cnt_next = '0;
                    idle_cnt_next = '0;
                    state_next    = S_HOLD;
                end else if (BLANK_CYCLES != 0) begin
                    // Re-blanking an already blank display is harmless, so the
                    // counter simply keeps cycling while idle.
                    if (idle_cnt_reg == IDLE_LAST) begin
                        pixels_next   = '0;
                        blanked_next  = 1'b1;
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next    = S_IDLE;
                    busy_next     = 1'b0;
                    idle_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign pixels  = pixels_reg;
    assign ack     = ack_reg;
    assign owner   = owner_reg;
    assign busy    = busy_reg;
    assign blanked = blanked_reg;

endmodule

// File: tb/tb_max7219_frame_scheduler.sv
// Scoreboard bench for max7219_frame_scheduler (SIZE=2, NREQ=2, HOLD=4, BLANK=6).
// Stimulus pushes the expected grant (ack, pixels, owner) into a queue; a
// monitor pops and compares whenever ack is non-zero. Timing-specific
// expectations (latency, busy length, blank instant) are checked inline.
module tb_max7219_frame_scheduler;

    localparam int SIZE  = 2;
    localparam int NREQ  = 2;
    localparam int HOLD  = 4;
    localparam int BLANK = 6;
    localparam int FW    = 64 * SIZE;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      req = 2'b00;
    logic [FW-1:0]   slice0 = '0;
    logic [FW-1:0]   slice1 = '0;
    logic [2*FW-1:0] frame_in;
    logic [1:0]      ack;
    logic [FW-1:0]   pixels;
    logic            owner;
    logic            busy;
    logic            blanked;

    assign frame_in = {slice1, slice0};

    max7219_frame_scheduler #(
        .SIZE         (SIZE),
        .NREQ         (NREQ),
        .HOLD_CYCLES  (HOLD),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .frame_in (frame_in),
        .ack      (ack),
        .pixels   (pixels),
        .owner    (owner),
        .busy     (busy),
        .blanked  (blanked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    ack;
        logic [FW-1:0] pix;
        logic          owner;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [FW-1:0] p, input logic o);
        exp_t e;
        e.ack   = a;
        e.pix   = p;
        e.owner = o;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check("wait_idle_timeout", FW'(busy), '0);
    endtask

    // Monitor: every ack pulse is one transaction matched against the queue.
    always @(negedge clk) begin
        if (reset_n && ack != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack=%b expected no grant", ack);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn: ack=%b owner=%0d pixels=%h", ack, owner, pixels);
                check("sb_ack", FW'(ack), FW'(mon_e.ack));
                check("sb_pixels", pixels, mon_e.pix);
                check("sb_owner", FW'(owner), FW'(mon_e.owner));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int edge_n;
        int last_edge;
        int grants;
        logic [FW-1:0] p_a5;

        p_a5 = {16{8'hA5}};

        // Reset with both requests asserted
        reset_n = 1'b0;
        req     = 2'b11;
        slice0  = 128'h1234;
        slice1  = 128'h5678;
        step();
        step();
        check("rst_pixels",  pixels,          '0);
        check("rst_ack",     FW'(ack),        '0);
        check("rst_blanked", FW'(blanked),    FW'(1));
        check("rst_owner",   FW'(owner),      FW'(1));
        check("rst_busy",    FW'(busy),       '0);

        // Single requester, then idle blanking
        reset_n = 1'b1;
        req     = 2'b01;
        slice0  = p_a5;
        push(2'b01, p_a5, 1'b0);
        step();                                     // grant edge
        check("single_ack",    FW'(ack),     FW'(2'b01));
        check("single_pixels", pixels,       p_a5);
        check("single_busy",   FW'(busy),    FW'(1));
        check("single_blank0", FW'(blanked), '0);
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("single_busy_hold", FW'(busy), FW'(1));
            check("single_ack_low",   FW'(ack),  '0);
        end
        step();                                     // hold exit edge
        check("single_busy_end", FW'(busy), '0);
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("blank_pixels_early",  pixels,       p_a5);
        check("blank_flag_early",    FW'(blanked), '0);
        step();                                     // 6th idle edge
        check("blank_pixels", pixels,       '0);
        check("blank_flag",   FW'(blanked), FW'(1));

        slice1 = {16{8'h3C}};
        req    = 2'b10;
        push(2'b10, {16{8'h3C}}, 1'b1);
        step();
        check("unblank_ack",    FW'(ack),     FW'(2'b10));
        check("unblank_flag",   FW'(blanked), '0);
        check("unblank_pixels", pixels,       {16{8'h3C}});
        req = 2'b00;
        wait_idle(10);

        // Contention: both requesters held high
        slice0 = 128'h1;
        slice1 = 128'h2;
        push(2'b01, 128'h1, 1'b0);
        push(2'b10, 128'h2, 1'b1);
        push(2'b01, 128'h1, 1'b0);
        push(2'b10, 128'h2, 1'b1);
        req       = 2'b11;
        edge_n    = 0;
        last_edge = 0;
        grants    = 0;
        while (grants < 4 && edge_n < 40) begin
            step();
            edge_n++;
            if (ack != 2'b00) begin
                if (grants > 0) begin
                    check("grant_spacing", FW'(edge_n - last_edge), FW'(HOLD + 1));
                end
                last_edge = edge_n;
                grants++;
                if (grants == 4) begin
                    req = 2'b00;
                end
            end
        end
        check("contention_grants", FW'(grants), FW'(4));
        check("contention_first_latency", FW'(edge_n - 3 * (HOLD + 1)), FW'(1));
        req = 2'b00;
        wait_idle(10);

        // Request arriving during HOLD
        slice0 = 128'hDEAD_BEEF;
        slice1 = 128'hCAFE_F00D;
        req    = 2'b01;
        push(2'b01, 128'hDEAD_BEEF, 1'b0);
        step();
        check("dur_hold_ack0", FW'(ack), FW'(2'b01));
        req = 2'b00;
        step();
        check("dur_hold_ack_low", FW'(ack), '0);
        req = 2'b10;
        push(2'b10, 128'hCAFE_F00D, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("dur_hold_no_ack", FW'(ack), '0);
        end
        check("dur_hold_busy_end", FW'(busy), '0);
        step();                                     // first IDLE edge
        check("dur_hold_ack1",    FW'(ack), FW'(2'b10));
        check("dur_hold_pixels1", pixels,   128'hCAFE_F00D);
        req = 2'b00;

        // Reset in the middle of HOLD (hold_cnt == 2)
        step();
        step();
        reset_n = 1'b0;
        step();
        check("midrst_pixels",  pixels,       '0);
        check("midrst_busy",    FW'(busy),    '0);
        check("midrst_blanked", FW'(blanked), FW'(1));
        check("midrst_owner",   FW'(owner),   FW'(1));
        check("midrst_ack",     FW'(ack),     '0);
        reset_n = 1'b1;
        slice0  = 128'h5555;
        slice1  = 128'hAAAA;
        req     = 2'b11;
        push(2'b01, 128'h5555, 1'b0);
        step();
        check("postrst_ack",   FW'(ack),   FW'(2'b01));
        check("postrst_owner", FW'(owner), '0);
        req = 2'b00;
        wait_idle(10);
        step();
        step();

        check("sb_queue_empty", FW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
